// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared encodings for the instruction prefetch stage
// Purpose: fetch FSM state encoding, redirect-select encoding and the helper
//          that resolves simultaneous redirect requests by priority.
// Ports:   none (package).
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    SEL_NONE   = 2'd0,
    SEL_RESET  = 2'd1,
    SEL_BRANCH = 2'd2,
    SEL_JUMP   = 2'd3
  } redir_sel_e;

  // pc_reset beats is_branch, which beats is_jump.
  function automatic redir_sel_e redirect_select(input logic pc_reset,
                                                 input logic is_branch,
                                                 input logic is_jump);
    if (pc_reset)  return SEL_RESET;
    if (is_branch) return SEL_BRANCH;
    if (is_jump)   return SEL_JUMP;
    return SEL_NONE;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO holding prefetched {address, word} entries
// Purpose: DEPTH-entry buffer with flush; push and pop may coincide, even when full.
// Ports:   clk, reset (sync, active-high); push/wdata write the tail; pop drops
//          the head; flush empties the buffer and wins over push/pop;
//          rdata is the head entry; full, empty, count report occupancy.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A push into a full buffer is only legal when the head leaves this cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/if_prefetch.sv
// rtl/if_prefetch.sv - sequential instruction prefetcher with redirect flush
// Purpose: fetches sequential words through a req/ack arbiter port into a
//          DEPTH-entry buffer and hands them to decode with valid/ready.
// Ports:   clk, reset (sync, active-high); pc_reset/is_branch/is_jump with
//          branch_addr/jump_addr redirect the stream; read_req/read_addr/
//          read_ack/read_data form the arbiter port; out_valid/out_ready/
//          instruction/pc/pc_next present the head; flushed pulses once
//          after a redirect.
module if_prefetch
  import fetch_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                DEPTH       = 4,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                INSTR_BYTES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_reset,
  input  logic              is_branch,
  input  logic              is_jump,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              read_req,
  input  logic              read_ack,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [DATA_W-1:0] read_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] instruction,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next,
  output logic              flushed
);

  localparam int                CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(INSTR_BYTES);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              req_d;
  logic [ADDR_W-1:0] addr_d;
  redir_sel_e        sel;
  logic              redirect;
  logic [ADDR_W-1:0] target;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  cnt_next;
  logic              room;
  logic              fifo_empty;
  logic              unused_full;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  assign sel      = redirect_select(pc_reset, is_branch, is_jump);
  assign redirect = (sel != SEL_NONE);

  always_comb begin
    target = fetch_pc_q;
    case (sel)
      SEL_RESET:  target = RESET_PC;
      SEL_BRANCH: target = branch_addr;
      SEL_JUMP:   target = jump_addr;
      default:    target = fetch_pc_q;
    endcase
  end

  // Acks in DRAIN close a stale request and never reach the buffer; a
  // redirect discards a same-cycle ack and overrides a same-cycle pop.
  assign push     = (state_q == ST_REQ) && read_ack && !redirect;
  assign pop      = out_valid && out_ready && !redirect;
  assign cnt_next = fifo_count + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
  assign room     = (cnt_next < DEPTH_CNT);

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata ({read_addr, read_data}),
    .rdata ({head_addr, head_data}),
    .full  (unused_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_d      = read_req;
    addr_d     = read_addr;
    case (state_q)
      ST_IDLE: begin
        if (redirect) begin
          fetch_pc_d = target;
          state_d    = ST_REQ;
          req_d      = 1'b1;
          addr_d     = target;
        end else if (room) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          addr_d  = fetch_pc_q;
        end
      end
      ST_REQ: begin
        if (redirect) begin
          fetch_pc_d = target;
          // Without an ack the old request must still be completed.
          if (read_ack) addr_d  = target;
          else          state_d = ST_DRAIN;
        end else if (read_ack) begin
          fetch_pc_d = fetch_pc_q + PC_STEP;
          if (room) begin
            addr_d = fetch_pc_q + PC_STEP;
          end else begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
          end
        end
      end
      ST_DRAIN: begin
        if (redirect) fetch_pc_d = target;
        if (read_ack) begin
          state_d = ST_REQ;
          addr_d  = redirect ? target : fetch_pc_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      read_req   <= 1'b0;
      read_addr  <= '0;
      flushed    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      read_req   <= req_d;
      read_addr  <= addr_d;
      flushed    <= redirect;
    end
  end

  // Head fields read as zero while the buffer is empty.
  assign out_valid   = !fifo_empty;
  assign instruction = out_valid ? head_data : '0;
  assign pc          = out_valid ? head_addr : '0;
  assign pc_next     = out_valid ? head_addr + PC_STEP : '0;

endmodule

// File: tb/tb_if_prefetch.sv
// tb/tb_if_prefetch.sv - self-checking bench for if_prefetch
module tb_if_prefetch;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pc_reset = 1'b0;
  logic        is_branch = 1'b0;
  logic        is_jump = 1'b0;
  logic [31:0] branch_addr = '0;
  logic [31:0] jump_addr = '0;
  logic        read_req;
  logic        read_ack = 1'b0;
  logic [31:0] read_addr;
  logic [31:0] read_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        flushed;

  int checks = 0;
  int errors = 0;

  if_prefetch #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .INSTR_BYTES(4)
  ) dut (
    .clk(clk), .reset(reset), .pc_reset(pc_reset), .is_branch(is_branch),
    .is_jump(is_jump), .branch_addr(branch_addr), .jump_addr(jump_addr),
    .read_req(read_req), .read_ack(read_ack), .read_addr(read_addr),
    .read_data(read_data), .out_valid(out_valid), .out_ready(out_ready),
    .instruction(instruction), .pc(pc), .pc_next(pc_next), .flushed(flushed)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of delivered words plus one outstanding request
  // that may have been made stale by a redirect.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_fetch_pc = '0;
  logic [31:0] m_out_addr = '0;
  bit          m_out = 1'b0;
  bit          m_stale = 1'b0;
  bit          m_flushed = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit          acked;
    bit          redir;
    logic [31:0] tgt;
    if (reset) begin
      mq.delete();
      m_fetch_pc = '0;
      m_out      = 1'b0;
      m_out_addr = '0;
      m_stale    = 1'b0;
      m_flushed  = 1'b0;
      return;
    end
    redir = pc_reset | is_branch | is_jump;
    tgt   = pc_reset ? 32'h0 : (is_branch ? branch_addr : jump_addr);
    acked = m_out && read_ack;
    if (redir) begin
      mq.delete();
      m_fetch_pc = tgt;
      m_flushed  = 1'b1;
      if (m_out && !acked) begin
        m_stale = 1'b1;
      end else begin
        m_out      = 1'b1;
        m_out_addr = tgt;
        m_stale    = 1'b0;
      end
    end else begin
      m_flushed = 1'b0;
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (acked) begin
        if (!m_stale) begin
          mq.push_back('{m_out_addr, read_data});
          m_fetch_pc = m_fetch_pc + 32'd4;
        end
        m_out   = 1'b0;
        m_stale = 1'b0;
      end
      if (!m_out && mq.size() < DEPTH) begin
        m_out      = 1'b1;
        m_out_addr = m_fetch_pc;
      end
    end
  endtask

  task automatic compare_model();
    chk("model_read_req", read_req, m_out);
    if (m_out) chk("model_read_addr", read_addr, m_out_addr);
    chk("model_out_valid", out_valid, mq.size() > 0);
    chk("model_flushed", flushed, m_flushed);
    if (mq.size() > 0) begin
      chk("model_pc", pc, mq[0].addr);
      chk("model_instruction", instruction, mq[0].data);
      chk("model_pc_next", pc_next, mq[0].addr + 32'd4);
    end
  endtask

  task automatic drive(input bit rst, input bit pr, input bit br, input bit jp,
                       input bit ack, input bit rdy, input logic [31:0] rdata,
                       input logic [31:0] baddr, input logic [31:0] jaddr);
    reset       = rst;
    pc_reset    = pr;
    is_branch   = br;
    is_jump     = jp;
    read_ack    = ack;
    out_ready   = rdy;
    read_data   = rdata;
    branch_addr = baddr;
    jump_addr   = jaddr;
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cycle(input bit rst, input bit pr, input bit br, input bit jp,
                       input bit ack, input bit rdy, input logic [31:0] rdata,
                       input logic [31:0] baddr, input logic [31:0] jaddr);
    drive(rst, pr, br, jp, ack, rdy, rdata, baddr, jaddr);
    @(negedge clk);
    compare_model();
    finish_cycle();
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
  endtask

  typedef struct {
    bit          rst;
    bit          ack;
    bit          rdy;
    logic [31:0] rdata;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_ov;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pcn;
    bit          e_fl;
  } vec_t;

  vec_t vt[8];

  initial begin
    vt[0] = '{1, 0, 1, 32'h0,         0, 32'h0, 0, 32'h0, 32'h0,         32'h0, 0};
    vt[1] = '{0, 0, 1, 32'h0,         0, 32'h0, 0, 32'h0, 32'h0,         32'h0, 0};
    vt[2] = '{0, 1, 1, 32'h1111_0000, 1, 32'h0, 0, 32'h0, 32'h0,         32'h0, 0};
    vt[3] = '{0, 0, 1, 32'h0,         1, 32'h4, 1, 32'h0, 32'h1111_0000, 32'h4, 0};
    vt[4] = '{0, 1, 1, 32'h2222_0004, 1, 32'h4, 0, 32'h0, 32'h0,         32'h0, 0};
    vt[5] = '{0, 0, 1, 32'h0,         1, 32'h8, 1, 32'h4, 32'h2222_0004, 32'h8, 0};
    vt[6] = '{0, 1, 1, 32'h3333_0008, 1, 32'h8, 0, 32'h0, 32'h0,         32'h0, 0};
    vt[7] = '{0, 0, 1, 32'h0,         1, 32'hC, 1, 32'h8, 32'h3333_0008, 32'hC, 0};

    repeat (2) @(posedge clk);
    #1;

    // Reset release, ack every second cycle, decode always ready.
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].rst, 0, 0, 0, vt[i].ack, vt[i].rdy, vt[i].rdata, 32'h0, 32'h0);
      @(negedge clk);
      compare_model();
      chk("tbl_read_req", read_req, vt[i].e_req);
      chk("tbl_read_addr", read_addr, vt[i].e_addr);
      chk("tbl_out_valid", out_valid, vt[i].e_ov);
      chk("tbl_pc", pc, vt[i].e_pc);
      chk("tbl_instruction", instruction, vt[i].e_instr);
      chk("tbl_pc_next", pc_next, vt[i].e_pcn);
      chk("tbl_flushed", flushed, vt[i].e_fl);
      finish_cycle();
    end

    // Fill with decode stalled, then one pop re-issues at 0x10.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1, 0, 32'hA0 + i, 32'h0, 32'h0);
    chk("fill_req_low", read_req, 1'b0);
    chk("fill_valid", out_valid, 1'b1);
    cycle(0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0);
    chk("refill_req", read_req, 1'b1);
    chk("refill_addr", read_addr, 32'h10);
    chk("refill_head_pc", pc, 32'h4);

    // Branch to 0x100 while the request for 0x8 is pending.
    do_reset();
    cycle(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    cycle(0, 0, 0, 0, 1, 0, 32'hB0, 32'h0, 32'h0);
    cycle(0, 0, 0, 0, 1, 0, 32'hB4, 32'h0, 32'h0);
    cycle(0, 0, 1, 0, 0, 0, 32'h0, 32'h100, 32'h0);
    chk("drain_req", read_req, 1'b1);
    chk("drain_addr", read_addr, 32'h8);
    chk("drain_flushed", flushed, 1'b1);
    chk("drain_valid", out_valid, 1'b0);
    cycle(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    chk("drain_hold_addr", read_addr, 32'h8);
    chk("drain_flushed_pulse", flushed, 1'b0);
    cycle(0, 0, 0, 0, 1, 0, 32'hDEAD_DEAD, 32'h0, 32'h0);
    chk("drain_next_addr", read_addr, 32'h100);
    chk("drain_dropped", out_valid, 1'b0);
    cycle(0, 0, 0, 0, 1, 0, 32'hBEEF_0100, 32'h0, 32'h0);
    chk("branch_pc", pc, 32'h100);
    chk("branch_instr", instruction, 32'hBEEF_0100);

    // Branch and jump together with an ack, then pc_reset over both.
    do_reset();
    cycle(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    cycle(0, 0, 1, 1, 1, 1, 32'hBAD0_0000, 32'h200, 32'h300);
    chk("prio_branch_addr", read_addr, 32'h200);
    chk("prio_branch_valid", out_valid, 1'b0);
    cycle(0, 1, 1, 1, 1, 1, 32'hBAD0_0200, 32'h200, 32'h300);
    chk("prio_reset_addr", read_addr, 32'h0);
    chk("prio_reset_flushed", flushed, 1'b1);
    cycle(0, 0, 0, 0, 1, 0, 32'h5A5A_5A5A, 32'h0, 32'h0);
    chk("prio_reset_instr", instruction, 32'h5A5A_5A5A);

    // Redirect coinciding with a pop of a full buffer.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1, 0, 32'hC0 + i, 32'h0, 32'h0);
    cycle(0, 0, 0, 1, 1, 1, 32'hBAD, 32'h0, 32'h40);
    chk("flushpop_valid", out_valid, 1'b0);
    chk("flushpop_addr", read_addr, 32'h40);
    cycle(0, 0, 0, 0, 1, 0, 32'h4040_4040, 32'h0, 32'h0);
    chk("flushpop_pc", pc, 32'h40);

    // Reset asserted mid-request.
    do_reset();
    cycle(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    cycle(0, 0, 0, 0, 1, 0, 32'hE0, 32'h0, 32'h0);
    cycle(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    chk("midreset_req", read_req, 1'b0);
    chk("midreset_valid", out_valid, 1'b0);
    cycle(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    chk("midreset_req_again", read_req, 1'b1);
    chk("midreset_addr", read_addr, 32'h0);

    // Randomised traffic against the model, including address wrap.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ba;
      logic [31:0] ja;
      ba = ($urandom % 8 == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      ja = $urandom & 32'hFFFF_FFFC;
      cycle(($urandom % 200) == 0, ($urandom % 64) == 0, ($urandom % 16) == 0,
            ($urandom % 16) == 0, ($urandom % 2) == 0, ($urandom % 10) < 6,
            $urandom, ba, ja);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_prefetch.md
Name: if_prefetch

Overview:
- Parametrised successor of the single-shot fetch stage.
- Fetches sequential instruction words through the memory arbiter's req/ack port into a DEPTH-entry prefetch buffer.
- Presents instructions to decode with a valid/ready handshake.
- Supports pc_reset, branch and jump redirects that flush the buffer and discard any in-flight fetch.

Parameters:
- ADDR_W, 32, width of the PC and arbiter address.
- DATA_W, 32, instruction word width.
- DEPTH, 4, prefetch buffer entries (power of two, >=2).
- RESET_PC, 0, first fetch address after reset or pc_reset.
- INSTR_BYTES, 4, PC increment per instruction.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- pc_reset  in  1  redirect to RESET_PC.
- is_branch  in  1  redirect to branch_addr.
- is_jump  in  1  redirect to jump_addr.
- branch_addr  in  ADDR_W  branch target.
- jump_addr  in  ADDR_W  jump target.
- read_req  out  1  arbiter request (registered).
- read_ack  in  1  single-cycle ack; read_data valid in that cycle.
- read_addr  out  ADDR_W  fetch address (registered, stable while read_req=1 and no ack).
- read_data  in  DATA_W  fetched word.
- out_valid  out  1  head entry valid.
- out_ready  in  1  decode accepts head.
- instruction  out  DATA_W  head instruction.
- pc  out  ADDR_W  address of head instruction.
- pc_next  out  ADDR_W  pc + INSTR_BYTES.
- flushed  out  1  one-cycle pulse after any redirect takes effect.

Behaviour:
- Clocking and reset:
  - One clock domain; clk and reset are named as elsewhere in the codebase.
  - reset is synchronous and active-high.
  - Reset values: read_req=0, read_addr=0, out_valid=0, instruction=0, pc=0, pc_next=0, flushed=0.
  - Reset values: buffer empty, fetch_pc=RESET_PC, state=IDLE.
- Redirect priority: pc_reset > is_branch > is_jump. Target = RESET_PC, branch_addr or jump_addr respectively.
- States:
  - IDLE: no outstanding read. If no redirect and cnt_next < DEPTH, go to REQ with read_req=1, read_addr=fetch_pc.
  - REQ:
    - read_req held at 1 with read_addr stable until read_ack.
    - On ack: write {read_addr, read_data} at the tail and set fetch_pc += INSTR_BYTES.
    - After the ack, if cnt_next < DEPTH, stay in REQ with read_addr = new fetch_pc (back-to-back; the arbiter treats each ack as closing one request). Otherwise go to IDLE with read_req=0.
  - DRAIN:
    - Entered on a redirect while in REQ without a same-cycle ack.
    - read_req stays 1 with the old address, because requests are never withdrawn.
    - On ack the data is dropped, then go to REQ at fetch_pc.
- cnt_next is the buffer count after this edge's push and pop. At most one read is outstanding, so the buffer never overflows.
- Redirect cycle:
  - Buffer flushed, fetch_pc=target, out_valid=0 next cycle, flushed=1 next cycle.
  - A same-cycle ack's data is discarded.
  - A same-cycle pop is ignored (the flush wins).
  - Redirect in IDLE: go to REQ at target next cycle.
  - Redirect in DRAIN: retarget only; stay in DRAIN.
- Output and pop:
  - out_valid = buffer non-empty; instruction/pc/pc_next reflect the head.
  - Pop when out_valid & out_ready.
  - Push and pop in the same cycle are allowed, including when full.
- Latency:
  - ack in cycle k: out_valid=1 in cycle k+1, when the buffer was empty.
  - First read_req=1 appears in the cycle after reset deasserts.
- Addresses wrap modulo 2^ADDR_W. Pointers wrap modulo DEPTH.
- A reset mid-request drops read_req immediately. The arbiter must tolerate this.

Decomposition:
- Package fetch_pkg: state encodings (IDLE, REQ, DRAIN) and the redirect-select constants.
- Sub-module fetch_fifo: synchronous FIFO with parameters DEPTH and WIDTH=ADDR_W+DATA_W, and ports push, pop, flush, full, empty, count.
- Instance in if_prefetch; FSM and PC logic stay in the top.

Test Plan:
- Reset release, ack every 2nd cycle, out_ready=1:
  - read_addr sequence is 0x0, 0x4, 0x8.
  - Decode sees pc=0x0/0x4/0x8 with matching data, and pc_next=pc+4.
- out_ready=0, ack always 1, DEPTH=4:
  - Exactly 4 entries fill, then read_req=0.
  - One pop re-issues a request at 0x10.
- Branch to 0x100 while a request for 0x8 is pending:
  - read_req stays high at 0x8 until ack; that data is dropped.
  - The next request is at 0x100; first out pc=0x100; flushed pulse seen.
- Same cycle is_branch=1 (0x200) and is_jump=1 (0x300) with ack: ack data discarded, next fetch 0x200. pc_reset with both set gives RESET_PC.
- Redirect to 0x40 in the same cycle as a pop with a full buffer: buffer empty next cycle, no stale pc delivered.
- Reset asserted mid-REQ: next cycle read_req=0 and out_valid=0; after release the first fetch is at RESET_PC.
